// File: rtl/lsnn_spike_decoder.sv
// Spike-train decoder: rate, first-spike latency and last ISI over a programmable window.
// Results are presented on a valid/ready port; a window can restart directly from the handshake edge.
module lsnn_spike_decoder #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] win_len,
  input  logic          spike_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] rate,
  output logic [CW-1:0] first_lat,
  output logic [CW-1:0] isi,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] len_q;
  logic [CW-1:0] samp_cnt;
  logic [CW-1:0] spk_cnt;
  logic [CW-1:0] first_q;
  logic [CW-1:0] isi_q;
  logic [CW-1:0] gap;
  logic          seen;

  logic [CW-1:0] spk_nxt;
  logic [CW-1:0] first_nxt;
  logic [CW-1:0] isi_nxt;
  logic [CW-1:0] gap_nxt;
  logic          seen_nxt;
  logic          start;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign start = en && (win_len != '0);

  // Working-counter update for the sample currently on spike_in (index samp_cnt).
  always_comb begin
    spk_nxt   = spk_cnt;
    first_nxt = first_q;
    isi_nxt   = isi_q;
    gap_nxt   = sat_inc(gap);
    seen_nxt  = seen;
    if (spike_in) begin
      spk_nxt = spk_cnt + CW'(1);
      if (!seen) begin
        first_nxt = samp_cnt;
        seen_nxt  = 1'b1;
      end else begin
        isi_nxt = gap + CW'(1);
      end
      gap_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      samp_cnt  <= '0;
      spk_cnt   <= '0;
      first_q   <= '0;
      isi_q     <= '0;
      gap       <= '0;
      seen      <= 1'b0;
      out_valid <= 1'b0;
      rate      <= '0;
      first_lat <= '0;
      isi       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= win_len;
            samp_cnt <= CW'(1);
            spk_cnt  <= '0;
            first_q  <= '0;
            isi_q    <= '0;
            gap      <= '0;
            seen     <= 1'b0;
            busy     <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          spk_cnt  <= spk_nxt;
          first_q  <= first_nxt;
          isi_q    <= isi_nxt;
          gap      <= gap_nxt;
          seen     <= seen_nxt;
          samp_cnt <= samp_cnt + CW'(1);
          // Last sample: publish results that already include this sample.
          if (samp_cnt == len_q) begin
            rate      <= spk_nxt;
            first_lat <= first_nxt;
            isi       <= isi_nxt;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              len_q    <= win_len;
              samp_cnt <= CW'(1);
              spk_cnt  <= '0;
              first_q  <= '0;
              isi_q    <= '0;
              gap      <= '0;
              seen     <= 1'b0;
              busy     <= 1'b1;
              state    <= COUNT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
